// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode enum, flag bundle, FSM states.
// ALU_WIDTH sets the default word width used by alu_mc, alu_mc_if and the testbench.
package alu_mc_pkg;

  localparam int ALU_WIDTH = 8;

  typedef logic [ALU_WIDTH-1:0] word_t;

  // Codes 0..6 keep their original values from the single-cycle ALU.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NOT  = 4'd4,
    OP_SLT  = 4'd5,
    OP_NOP  = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLTS = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIV  = 4'd12,
    OP_MOD  = 4'd13
  } e_alu_op;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
    logic div0;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input e_alu_op op);
    return op inside {OP_MUL, OP_DIV, OP_MOD};
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the control unit (master) and the ALU (slave).
interface alu_mc_if
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  e_alu_op          op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             negative;
  logic             div0;

  modport master (
    output in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow, negative, div0
  );

  modport slave (
    input  in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow, negative, div0
  );
endinterface

// File: rtl/alu_mc_muldiv_iter.sv
// Iterative unit: shift-add multiply (mode=0) or restoring divide (mode=1), one bit per cycle.
// The first step runs on the start edge so done arrives WIDTH-1 cycles later; built only with ALU_MULDIV_EN.
`ifdef ALU_MULDIV_EN
module alu_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic             mode_q;
  logic [WIDTH-1:0] b_q;
  logic             load;
  logic             cur_mode;
  logic [WIDTH-1:0] cur_hi, cur_lo, cur_b;
  logic [WIDTH:0]   madd, dsh;
  logic [WIDTH-1:0] dsub;
  logic             dge;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  assign load     = start && !busy;
  assign cur_mode = load ? mode : mode_q;
  assign cur_hi   = load ? '0 : hi;
  assign cur_lo   = load ? a : lo;
  assign cur_b    = load ? b : b_q;

  // {hi,lo} is the product register for multiply and {remainder,quotient} for divide.
  assign madd = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
  assign dsh  = {cur_hi, cur_lo[WIDTH-1]};
  assign dge  = dsh >= {1'b0, cur_b};
  assign dsub = WIDTH'(dsh - {1'b0, cur_b});

  assign nxt_hi = cur_mode ? (dge ? dsub : dsh[WIDTH-1:0]) : madd[WIDTH:1];
  assign nxt_lo = cur_mode ? {cur_lo[WIDTH-2:0], dge} : {madd[0], cur_lo[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      mode_q <= 1'b0;
      b_q    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        busy   <= 1'b1;
        cnt    <= CW'(WIDTH - 1);
        mode_q <= mode;
        b_q    <= b;
        hi     <= nxt_hi;
        lo     <= nxt_lo;
      end else if (busy) begin
        hi  <= nxt_hi;
        lo  <= nxt_lo;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule
`endif

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops registered in one cycle; MUL/DIV/MOD iterate WIDTH+1 cycles
// when ALU_MULDIV_EN is defined, otherwise they return 0 in one cycle. Result held until out_ready.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;
  logic             accept, load;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] sc_res, res_n;
  logic             sc_carry, sc_ovf, carry_n, ovf_n, div0_n;

  assign a    = bus.src_a;
  assign b    = bus.src_b;
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  assign bus.in_ready = (state_q == ST_IDLE) || (state_q == ST_DONE && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        sc_res   = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res   = diff[WIDTH-1:0];
        sc_carry = diff[WIDTH];
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOT:  sc_res = ~b;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLTS: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHL:  sc_res = a << b[SHAMT_W-1:0];
      OP_SHR:  sc_res = a >> b[SHAMT_W-1:0];
      OP_NOP:  sc_res = a;
      default: sc_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  e_alu_op          op_q;
  logic             b_zero_q;
  logic             it_start, it_busy, it_done;
  logic [WIDTH-1:0] it_lo, it_hi;

  assign it_start = accept && is_muldiv(bus.op);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (it_start),
    .mode  (bus.op != OP_MUL),
    .a     (a),
    .b     (b),
    .busy  (it_busy),
    .done  (it_done),
    .lo    (it_lo),
    .hi    (it_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_NOP;
      b_zero_q <= 1'b0;
    end else if (it_start) begin
      op_q     <= bus.op;
      b_zero_q <= (b == '0);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    res_n   = sc_res;
    carry_n = sc_carry;
    ovf_n   = sc_ovf;
    div0_n  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
`ifdef ALU_MULDIV_EN
          if (is_muldiv(bus.op)) begin
            state_d = ST_BUSY;
          end else begin
            state_d = ST_DONE;
            load    = 1'b1;
          end
`else
          state_d = ST_DONE;
          load    = 1'b1;
`endif
        end else if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
`ifdef ALU_MULDIV_EN
      ST_BUSY: begin
        // Divide-by-zero needs no special case: the restoring loop yields all ones / A.
        res_n   = (op_q == OP_MOD) ? it_hi : it_lo;
        carry_n = (op_q == OP_MUL) && (it_hi != '0);
        ovf_n   = 1'b0;
        div0_n  = (op_q != OP_MUL) && b_zero_q;
        if (it_done) begin
          state_d = ST_DONE;
          load    = 1'b1;
        end else if (!it_busy) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        result_q          <= res_n;
        flags_q.zero      <= (res_n == '0);
        flags_q.carry     <= carry_n;
        flags_q.overflow  <= ovf_n;
        flags_q.negative  <= res_n[WIDTH-1];
        flags_q.div0      <= div0_n;
      end
    end
  end

  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = flags_q.zero;
  assign bus.carry     = flags_q.carry;
  assign bus.overflow  = flags_q.overflow;
  assign bus.negative  = flags_q.negative;
  assign bus.div0      = flags_q.div0;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at WIDTH=8; expectations adapt to whether ALU_MULDIV_EN is defined.
module tb_alu_mc;
  import alu_mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_mc_if #(.WIDTH(8)) bus ();

  alu_mc #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       op;
    int       a;
    int       b;
    int       res;
    logic [4:0] fl;  // {zero, carry, overflow, negative, div0}
    int       lat;
  } vec_t;

  function automatic int sgn8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference model straight from the operation definitions, using integer arithmetic.
  function automatic void model(input int op, input int a, input int b,
                                output int res, output logic [4:0] fl, output int lat);
    int c, o, d, s;
    res = 0; c = 0; o = 0; d = 0; lat = 1;
    case (op)
      0: begin s = a + b; res = s % 256; c = (s > 255); s = sgn8(a) + sgn8(b); o = (s > 127 || s < -128); end
      1: begin res = (a - b + 256) % 256; c = (a < b); s = sgn8(a) - sgn8(b); o = (s > 127 || s < -128); end
      2: res = a & b;
      3: res = a | b;
      4: res = 255 - b;
      5: res = (a < b) ? 1 : 0;
      6: res = a;
      7: res = a ^ b;
      8: res = (sgn8(a) < sgn8(b)) ? 1 : 0;
      9: res = (a * (1 << (b % 8))) % 256;
      10: res = a / (1 << (b % 8));
`ifdef ALU_MULDIV_EN
      11: begin res = (a * b) % 256; c = ((a * b) > 255); lat = 9; end
      12: begin lat = 9; if (b == 0) begin res = 255; d = 1; end else res = a / b; end
      13: begin lat = 9; if (b == 0) begin res = a; d = 1; end else res = a % b; end
`endif
      default: res = 0;
    endcase
    fl = {res == 0, c[0], o[0], res >= 128, d[0]};
  endfunction

  // Issue one request from idle, wait (bounded) for the result, capture it, then consume it.
  task automatic issue(input int op, input int a, input int b,
                       output int lat, output int res, output logic [4:0] fl);
    int n;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = e_alu_op'(op[3:0]);
    bus.src_a     = a[7:0];
    bus.src_b     = b[7:0];
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.src_a    = 8'($urandom);
    bus.src_b    = 8'($urandom);
    bus.op       = e_alu_op'(4'($urandom));
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    lat = bus.out_valid ? n : -1;
    res = int'(bus.result);
    fl  = {bus.zero, bus.carry, bus.overflow, bus.negative, bus.div0};
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int stale;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_hs got valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.result !== 8'd0 || {bus.zero, bus.carry, bus.overflow, bus.negative, bus.div0} !== 5'b0) begin
      errors++; $display("FAIL reset_val got result=%0d flags=%b want 0/00000", bus.result,
                         {bus.zero, bus.carry, bus.overflow, bus.negative, bus.div0});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = OP_MUL; bus.src_a = 8'd20; bus.src_b = 8'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 8'd0) begin
      errors++; $display("FAIL reset_abort got valid=%b ready=%b result=%0d want 0/1/0",
                         bus.out_valid, bus.in_ready, bus.result);
    end
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++; $display("FAIL reset_stale got %0d valid cycles want 0", stale);
    end
  endtask

  task automatic test_directed();
    vec_t v[$];
    int lat, res;
    logic [4:0] fl;
    v.push_back('{op: 0, a: 200, b: 100, res: 44,  fl: 5'b01000, lat: 1});
    v.push_back('{op: 1, a: 100, b: 120, res: 236, fl: 5'b01010, lat: 1});
    v.push_back('{op: 0, a: 100, b: 100, res: 200, fl: 5'b00110, lat: 1});
    v.push_back('{op: 8, a: 255, b: 1,   res: 1,   fl: 5'b00000, lat: 1});
    v.push_back('{op: 5, a: 255, b: 1,   res: 0,   fl: 5'b10000, lat: 1});
    v.push_back('{op: 14, a: 77, b: 3,   res: 0,   fl: 5'b10000, lat: 1});
`ifdef ALU_MULDIV_EN
    v.push_back('{op: 11, a: 20,  b: 20, res: 144, fl: 5'b01010, lat: 9});
    v.push_back('{op: 12, a: 100, b: 7,  res: 14,  fl: 5'b00000, lat: 9});
    v.push_back('{op: 13, a: 100, b: 7,  res: 2,   fl: 5'b00000, lat: 9});
    v.push_back('{op: 12, a: 55,  b: 0,  res: 255, fl: 5'b00011, lat: 9});
    v.push_back('{op: 13, a: 55,  b: 0,  res: 55,  fl: 5'b00001, lat: 9});
`else
    v.push_back('{op: 11, a: 20,  b: 20, res: 0,   fl: 5'b10000, lat: 1});
    v.push_back('{op: 12, a: 55,  b: 0,  res: 0,   fl: 5'b10000, lat: 1});
`endif
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, lat, res, fl);
      checks++;
      if (res !== v[i].res || fl !== v[i].fl || lat !== v[i].lat) begin
        errors++;
        $display("FAIL directed op=%0d a=%0d b=%0d got res=%0d flags=%b lat=%0d want res=%0d flags=%b lat=%0d",
                 v[i].op, v[i].a, v[i].b, res, fl, lat, v[i].res, v[i].fl, v[i].lat);
      end
    end
  endtask

  task automatic test_random();
    int op, a, b, lat, res, elat, eres;
    logic [4:0] fl, efl;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, 255);
      b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      model(op, a, b, eres, efl, elat);
      issue(op, a, b, lat, res, fl);
      checks++;
      if (res !== eres) begin
        errors++; $display("FAIL rnd_result op=%0d a=%0d b=%0d got %0d want %0d", op, a, b, res, eres);
      end
      checks++;
      if (fl !== efl) begin
        errors++; $display("FAIL rnd_flags op=%0d a=%0d b=%0d got %b want %b", op, a, b, fl, efl);
      end
      checks++;
      if (lat !== elat) begin
        errors++; $display("FAIL rnd_latency op=%0d got %0d want %0d", op, lat, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.op = OP_SHL; bus.src_a = 8'h81; bus.src_b = 8'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 8'h02 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle=%0d got valid=%b result=%h ready=%b want 1/02/0",
                           k, bus.out_valid, bus.result, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1; bus.op = OP_ADD; bus.src_a = 8'd7; bus.src_b = 8'd9;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready got %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'd16) begin
      errors++; $display("FAIL bp_next got valid=%b result=%0d want 1/16", bus.out_valid, bus.result);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int a, b, eres, elat;
    logic [4:0] efl;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      model(0, a, b, eres, efl, elat);
      bus.in_valid = 1'b1; bus.op = OP_ADD; bus.src_a = a[7:0]; bus.src_b = b[7:0];
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || int'(bus.result) !== eres || bus.carry !== efl[3]) begin
        errors++; $display("FAIL b2b i=%0d got valid=%b result=%0d carry=%b want 1/%0d/%b",
                           i, bus.out_valid, bus.result, bus.carry, eres, efl[3]);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got valid=%b want 0", bus.out_valid);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = OP_NOP;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU that replaces the single-cycle combinational ALU in the datapath.
- Single-cycle ops: add, sub, logic, compare and shift. Each takes one registered cycle.
- Multi-cycle ops: iterative multiply, divide and modulo.
- Status flags are registered with the result.
- Valid/ready handshakes on input and output let the control unit stall on long ops.

Parameters:
WIDTH, 8, operand/result width in bits (>=4); the package word type equals logic [WIDTH-1:0] at default.
SHAMT_W, $clog2(WIDTH), number of low src_b bits used as shift amount.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request this cycle
op  in  e_alu_op (4)  operation code
src_a  in  WIDTH  operand A
src_b  in  WIDTH  operand B
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
zero  out  1  result == 0
carry  out  1  add carry-out, sub borrow, mul high-half nonzero
overflow  out  1  signed overflow for ADD/SUB, else 0
negative  out  1  result[WIDTH-1]
div0  out  1  DIV/MOD with src_b == 0

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE; result=0; all flags=0; out_valid=0; in_ready=1.
- Reset mid-operation: aborts any in-flight op with no output and returns to IDLE next cycle.
- Accept: a transfer occurs when in_valid && in_ready. Operands and op are latched on accept; later input changes are ignored.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterative op running; in_ready=0, out_valid=0.
  - DONE: out_valid=1; result and flags held stable until out_ready.
- Transitions:
  - IDLE, accept of a single-cycle op -> DONE next cycle (latency 1).
  - IDLE, accept of MUL/DIV/MOD -> BUSY. The counter runs WIDTH cycles, then -> DONE (latency WIDTH+1).
  - DONE, out_ready=1 -> IDLE.
- in_ready in DONE: equals out_ready. A new request may be accepted in the same cycle the result is consumed (back-to-back, no bubble); it goes to DONE or BUSY as above.
- Ops:
  - ADD: result = A+B mod 2^WIDTH; carry = bit WIDTH of the sum.
  - SUB: result = A-B; carry = borrow (A<B unsigned).
  - AND, OR, XOR: bitwise A op B.
  - NOT: result = ~B.
  - SLT: result = (A<B, unsigned) zero-extended.
  - SLTS: result = (A<B, signed) zero-extended.
  - SHL: result = A << B[SHAMT_W-1:0].
  - SHR: result = A >> B[SHAMT_W-1:0], logical.
  - NOP: result = A.
  - MUL: result = low WIDTH bits of the unsigned product; carry = (high half != 0).
  - DIV: unsigned restoring divide; result = quotient.
  - MOD: unsigned restoring divide; result = remainder.
  - Undefined op: result = 0.
- Overflow: ADD/SUB only; set when operand signs give a result-sign mismatch.
- Divide by zero: result = all ones for DIV, A for MOD; div0=1. Still takes WIDTH+1 cycles.
- Flag defaults: carry=0 for ops not listed; div0=0 except DIV/MOD with B==0.
- Flag timing: zero and negative derive from the final registered result. All flags update only on entry to DONE.

Optional Feature:
Macro: ALU_MULDIV_EN.
- Defined: MUL/DIV/MOD use the iterative unit exactly as above.
- Undefined:
  - The iterative unit and the BUSY state are not built.
  - MUL/DIV/MOD complete in 1 cycle with result=0, carry=0 and div0=0.
  - Every op has latency 1.

Decomposition:
- project_pkg holds:
  - the e_alu_op enum extended with XOR, SLTS, SHL, SHR, MUL, DIV, MOD (4-bit encoding; existing codes unchanged);
  - the alu_flags_t packed struct {zero, carry, overflow, negative, div0}.
- Sub-module alu_muldiv_iter: shift-add multiplier and restoring divider.
  - Interface: start, mode, a, b, busy, done, lo, hi.
  - Instantiated only under ALU_MULDIV_EN.

Test Plan:
WIDTH=8 for all scenarios.
- Reset: hold rst 2 cycles during BUSY (MUL started) -> out_valid=0, in_ready=1, result=0 the cycle after rst falls; no stale result appears.
- ADD 200+100 -> result=44, carry=1, overflow=0, 1 cycle after accept. SUB 100-120 -> result=236, carry=1, negative=1. ADD 100+100 -> 200, overflow=1.
- MUL 20*20 -> result=144, carry=1, out_valid exactly 9 cycles after accept. DIV 100/7 -> 14; MOD 100/7 -> 2.
- DIV 55/0 -> result=255, div0=1. MOD 55/0 -> 55, div0=1.
- Backpressure: SHL 0x81 by 1 with out_ready=0 for 3 cycles -> result=0x02 held stable, in_ready=0. Next request accepted in the cycle out_ready rises; back-to-back ADDs give one result per cycle.
- Build without ALU_MULDIV_EN: MUL 20*20 -> result=0 after 1 cycle, no BUSY state; SLTS 0xFF<0x01 -> 1, SLT -> 0.
